// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle for pipe_stage_reg: controls and upstream slot in, registered slot out.
// Defaults match the stage register's defaults so an unparameterised pair connects cleanly.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int EXC_W     = 5,
  parameter int CNT_W     = 8
);
  logic                 En;
  logic                 Flush;
  logic                 Bubble;
  logic                 ValidIn;
  logic                 BDIn;
  logic [31:0]          InstrIn;
  logic [31:0]          PCIn;
  logic [4:0]           A3In;
  logic [PAYLOAD_W-1:0] PayloadIn;
  logic [EXC_W-1:0]     ExcIn;
  logic [EXC_W-1:0]     ExcNew;
  logic                 ValidOut;
  logic                 BDOut;
  logic [31:0]          InstrOut;
  logic [31:0]          PCOut;
  logic [4:0]           A3Out;
  logic [PAYLOAD_W-1:0] PayloadOut;
  logic [EXC_W-1:0]     ExcOut;
  logic                 HasExc;
  logic [CNT_W-1:0]     StallCnt;

  modport master (
    output En, Flush, Bubble, ValidIn, BDIn, InstrIn, PCIn, A3In, PayloadIn, ExcIn, ExcNew,
    input  ValidOut, BDOut, InstrOut, PCOut, A3Out, PayloadOut, ExcOut, HasExc, StallCnt
  );

  modport slave (
    input  En, Flush, Bubble, ValidIn, BDIn, InstrIn, PCIn, A3In, PayloadIn, ExcIn, ExcNew,
    output ValidOut, BDOut, InstrOut, PCOut, A3Out, PayloadOut, ExcOut, HasExc, StallCnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS inter-stage register with hold, flush, PC-preserving bubble and exception merge.
// One-cycle latency; En=0 holds the slot and counts consecutive stall cycles (saturating).
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 96,
  parameter int          EXC_W     = 5,
  parameter logic [31:0] PC_RST    = 32'h0000_3000,
  parameter int          CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  pipe_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic                 valid;
    logic                 bd;
    logic [31:0]          instr;
    logic [31:0]          pc;
    logic [4:0]           a3;
    logic [PAYLOAD_W-1:0] payload;
    logic [EXC_W-1:0]     exc;
  } stage_t;

  stage_t           st;
  logic [CNT_W-1:0] stall_cnt;
  logic [EXC_W-1:0] exc_merged;

  // The oldest exception in program order is the one already carried down the pipe.
  assign exc_merged = (bus.ExcIn != '0) ? bus.ExcIn : bus.ExcNew;

  always_ff @(posedge Clk) begin
    if (Reset || bus.Flush) begin
      st        <= '0;
      st.pc     <= PC_RST;
      stall_cnt <= '0;
    end else if (!bus.En) begin
      if (stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (bus.Bubble) begin
      st.valid   <= 1'b0;
      st.instr   <= '0;
      st.a3      <= '0;
      st.payload <= '0;
      st.exc     <= '0;
      st.pc      <= bus.PCIn;
      st.bd      <= bus.BDIn;
      stall_cnt  <= '0;
    end else begin
      st.valid   <= bus.ValidIn;
      st.bd      <= bus.BDIn;
      st.instr   <= bus.InstrIn;
      st.pc      <= bus.PCIn;
      st.payload <= bus.PayloadIn;
      st.a3      <= bus.ValidIn ? bus.A3In : 5'd0;
      st.exc     <= bus.ValidIn ? exc_merged : '0;
      stall_cnt  <= '0;
    end
  end

  assign bus.ValidOut   = st.valid;
  assign bus.BDOut      = st.bd;
  assign bus.InstrOut   = st.instr;
  assign bus.PCOut      = st.pc;
  assign bus.A3Out      = st.a3;
  assign bus.PayloadOut = st.payload;
  assign bus.ExcOut     = st.exc;
  assign bus.HasExc     = (st.exc != '0);
  assign bus.StallCnt   = stall_cnt;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage MIPS core. It is the successor to the fixed-width E/M latch and is instantiated for the D/E, E/M and M/W boundaries.
- Adds the following over the fixed latch: stall hold, a valid bit, two kinds of clear (full flush, and bubble that preserves PC/BD for EPC), first-exception-wins ExcCode merging, and a saturating stall-cycle counter for hazard debug.

Parameters:
- PAYLOAD_W, 96: width of the opaque stage payload (e.g. ALUOut, RD2, WD concatenated).
- EXC_W, 5: exception code width; code 0 means no exception.
- PC_RST, 32'h0000_3000: PCOut value on Reset and Flush.
- CNT_W, 8: stall counter width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  1 = advance; 0 = hold (stall).
- Flush  in  1  exception/eret flush: clears the whole stage, including PC.
- Bubble  in  1  insert a bubble: kills the instruction but keeps PC/BD.
- ValidIn  in  1  upstream slot holds a real instruction.
- BDIn  in  1  upstream instruction is in a delay slot.
- InstrIn  in  32  upstream instruction word.
- PCIn  in  32  upstream PC.
- A3In  in  5  destination register number.
- PayloadIn  in  PAYLOAD_W  stage data.
- ExcIn  in  EXC_W  exception code carried from earlier stages.
- ExcNew  in  EXC_W  exception detected in the upstream stage this cycle.
- ValidOut  out  1  registered valid.
- BDOut  out  1  registered delay-slot flag.
- InstrOut  out  32  registered instruction.
- PCOut  out  32  registered PC.
- A3Out  out  5  registered destination register.
- PayloadOut  out  PAYLOAD_W  registered payload.
- ExcOut  out  EXC_W  registered merged exception code.
- HasExc  out  1  combinational: ExcOut != 0.
- StallCnt  out  CNT_W  number of consecutive hold cycles.

Behaviour:
- All registers are updated on posedge Clk. Latency is one cycle from input to output.
- Action priority per edge: Reset > Flush > hold (En=0) > Bubble > load.
- Reset or Flush:
  - ValidOut=0, BDOut=0, InstrOut=0, A3Out=0, PayloadOut=0, ExcOut=0.
  - PCOut=PC_RST, StallCnt=0.
- Hold (En=0, no Reset/Flush):
  - Every data output keeps its value.
  - StallCnt increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - A Bubble asserted during a hold is ignored.
- Bubble (En=1, Bubble=1):
  - ValidOut=0, InstrOut=0, A3Out=0, PayloadOut=0, ExcOut=0.
  - PCOut<=PCIn, BDOut<=BDIn. This preserves EPC when an interrupt is taken on the bubble.
  - StallCnt=0.
- Load (En=1, Bubble=0):
  - ValidOut<=ValidIn, BDOut<=BDIn, InstrOut<=InstrIn, PCOut<=PCIn, PayloadOut<=PayloadIn.
  - If ValidIn=1: A3Out<=A3In, and ExcOut<=(ExcIn!=0)?ExcIn:ExcNew (the earliest exception wins).
  - If ValidIn=0: A3Out<=0 and ExcOut<=0, so invalid slots never write the register file or raise exceptions.
  - StallCnt=0.
- HasExc is purely combinational from ExcOut.
- Reset or Flush asserted in the middle of a stall clears the stage immediately and zeroes StallCnt.
- Flush and Bubble asserted together: Flush wins, and PCOut=PC_RST.
- The block contains no FSM beyond the priority mux and the counter. It must have no latches and no asynchronous paths.

Test Plan:
- Reset=1 for 2 cycles, then release with En=1, ValidIn=1, PCIn=32'h3004, InstrIn=32'h2408_0001, A3In=8. Required: PCOut=32'h3000 and all other outputs 0 during reset; one edge after release, PCOut=32'h3004, InstrOut=32'h2408_0001, A3Out=8, ValidOut=1.
- Load PCIn=32'h3010, then En=0 for 300 cycles while PCIn and InstrIn change. Required: outputs stay at 32'h3010; with CNT_W=8, StallCnt climbs to 255 and holds there; StallCnt=0 on the first edge with En=1.
- Load ValidIn=1 with ExcIn=0 and ExcNew=5'd4, then ExcIn=5'd10 with ExcNew=5'd4. Required: ExcOut=4 and HasExc=1 after the first edge; ExcOut=10 after the second edge.
- ValidIn=0, A3In=31, ExcNew=5'd12. Required: ValidOut=0, A3Out=0, ExcOut=0, PayloadOut equal to PayloadIn.
- Bubble=1 with PCIn=32'h3020 and BDIn=1, then Bubble=1 together with Flush=1. Required: after the first edge, InstrOut=0, ValidOut=0, PCOut=32'h3020, BDOut=1; after the second edge, PCOut=32'h3000 and BDOut=0.
- En=0 with Bubble=1 held for 3 cycles, then Flush=1 while En=0. Required: the bubble is ignored and the stage holds its prior contents; Flush clears everything including StallCnt on the next edge.
